// File: rtl/crc32_pkg.sv
// Shared CRC-32/MPEG-2 constants and the 32-bit-data next-CRC function.
// Bits are processed MSB-first, with no reflection and no final XOR.
package crc32_pkg;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // Unrolled by synthesis into one XOR network that does 32 serial LFSR steps at once.
    function automatic logic [31:0] crc32_d32(input logic [31:0] crc_in,
                                              input logic [31:0] data);
        logic [31:0] crc;
        logic        fb;
        crc = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb  = crc[31] ^ data[i];
            crc = {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return crc;
    endfunction

endpackage

// File: rtl/crc32_d32_next.sv
// Combinational parallel CRC-32/MPEG-2 update: one 32-bit word per evaluation.
module crc32_d32_next
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    output logic [31:0] crc_next
);

    assign crc_next = crc32_d32(crc_in, data);

endmodule

// File: rtl/crc32_parallel_pipeline.sv
// Two-stage CRC-32/MPEG-2 pipeline: stage 1 registers the input word, and
// stage 2 folds that word into the running CRC at one word per clock.
module crc32_parallel_pipeline
    import crc32_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        start_of_packet,
    input  logic [31:0] data_in,
    output logic [31:0] crc_out,
    output logic        valid_out
);

    logic [31:0] data_p1;
    logic        sop_p1;
    logic        vld_p1;
    logic [31:0] seed;
    logic [31:0] crc_next;

    // Stage 1: input register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_p1 <= 32'h0;
            sop_p1  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            data_p1 <= data_in;
            sop_p1  <= start_of_packet;
            vld_p1  <= enable;
        end
    end

    // Seeding from crc_out lets back-to-back words chain without a bypass.
    assign seed = sop_p1 ? CRC_INIT : crc_out;

    crc32_d32_next u_next (
        .crc_in   (seed),
        .data     (data_p1),
        .crc_next (crc_next)
    );

    // Stage 2: CRC update and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            crc_out   <= CRC_INIT;
            valid_out <= 1'b0;
        end else begin
            valid_out <= vld_p1;
            if (vld_p1) begin
                crc_out <= crc_next;
            end
        end
    end

endmodule

// File: tb/tb_crc32_parallel_pipeline.sv
// Scoreboard bench for crc32_parallel_pipeline: the stimulus process queues the
// expected results, and a monitor process checks each valid_out pulse.
module tb_crc32_parallel_pipeline;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        start_of_packet;
    logic [31:0] data_in;
    logic [31:0] crc_out;
    logic        valid_out;

    typedef struct {
        logic [31:0] crc;
        logic        chained;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          tests  = 0;
    int          fails  = 0;
    logic        prev_vld = 1'b0;
    logic [31:0] last_crc;

    crc32_parallel_pipeline dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .start_of_packet (start_of_packet),
        .data_in         (data_in),
        .crc_out         (crc_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    // Reference model: bit-serial MPEG-2 CRC over a byte stream
    function automatic logic [31:0] ref_crc(input logic [7:0] bytes[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (bytes[n]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[31] ^ bytes[n][b];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic sop, input logic en);
        @(posedge clk);
        #1;
        data_in         = d;
        start_of_packet = sop;
        enable          = en;
    endtask

    task automatic push(input logic [31:0] c, input logic ch, input string name);
        exp_t e;
        e.crc = c; e.chained = ch; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(32'h0, 1'b0, 1'b0);
    endtask

    // Monitor: consumes one expected entry per valid_out pulse
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check(e.name, crc_out, e.crc);
                check({e.name, "_consecutive"}, {31'h0, prev_vld}, {31'h0, e.chained});
                last_crc = crc_out;
            end
        end
        prev_vld = valid_out;
    end

    initial begin
        logic [7:0] two_words[$];
        two_words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        reset_n = 1'b0; enable = 1'b0; start_of_packet = 1'b0; data_in = 32'h0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_valid", {31'h0, valid_out}, 32'h0);
        check("reset_crc", crc_out, 32'hFFFFFFFF);
        reset_n = 1'b1;

        // Golden vector, then hold while idle
        push(32'hDF8A8A2B, 1'b0, "golden");
        drive(32'h12345678, 1'b1, 1'b1);
        idle(4);
        check("golden_hold", crc_out, 32'hDF8A8A2B);

        // Single-bit change in the data
        push(32'hDB4B979C, 1'b0, "error_detect");
        drive(32'h12345679, 1'b1, 1'b1);
        idle(3);

        // Two-word packet, back to back
        push(32'hDF8A8A2B, 1'b0, "two_word_first");
        push(ref_crc(two_words), 1'b1, "two_word_second");
        drive(32'h12345678, 1'b1, 1'b1);
        drive(32'h9ABCDEF0, 1'b0, 1'b1);
        idle(3);

        // A second sop restarts the CRC instead of chaining
        push(32'hDF8A8A2B, 1'b0, "restart_first");
        push(32'hDF8A8A2B, 1'b1, "restart_second");
        drive(32'h12345678, 1'b1, 1'b1);
        drive(32'h12345678, 1'b1, 1'b1);
        idle(3);

        // sop without enable must change nothing and produce no pulse
        drive(32'hCAFEF00D, 1'b1, 1'b0);
        idle(4);
        check("gated_sop_hold", crc_out, 32'hDF8A8A2B);

        // Reset one cycle after a word discards that word
        drive(32'h9ABCDEF0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b0; enable = 1'b0; start_of_packet = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_valid", {31'h0, valid_out}, 32'h0);
        check("midreset_crc", crc_out, 32'hFFFFFFFF);
        reset_n = 1'b1;
        idle(2);
        check("post_reset_hold", crc_out, 32'hFFFFFFFF);

        // First word after reset without sop seeds from the reset value
        push(32'hDF8A8A2B, 1'b0, "post_reset_nosop");
        drive(32'h12345678, 1'b0, 1'b1);
        idle(5);

        check("missing_valid_pulses", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end

endmodule

// File: doc/crc32_parallel_pipeline.md
CRC32_PARALLEL_PIPELINE -- requirements
Module: crc32_parallel_pipeline

Interface
REQ-001 The block SHALL have one clock and synchronous, active-low reset; clk and reset_n are the only clock and reset.
REQ-002 The block SHALL have no parameters; all CRC constants come from the shared package.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 enable  input  1  qualifies data_in and start_of_packet as a valid word this cycle.
REQ-006 start_of_packet  input  1  marks the qualified word as the first word of a packet; ignored when enable=0.
REQ-007 data_in  input  32  packet word; bit 31 is processed first.
REQ-008 crc_out  output  32  running CRC register, including the most recently completed word.
REQ-009 valid_out  output  1  one-cycle pulse per completed word; crc_out is valid while it is high.

Function
REQ-010 The CRC algorithm SHALL be CRC-32/MPEG-2: polynomial 0x04C11DB7, init 0xFFFFFFFF, MSB-first, no input or output reflection, no final XOR.
REQ-011 Per qualified word: seed = 0xFFFFFFFF if start_of_packet=1, else the current crc_out; new CRC = 32 serial MSB-first LFSR steps of seed with data_in, computed in one parallel combinational step.
REQ-012 The pipeline SHALL have two register stages:
  - stage 1 registers data_in, start_of_packet and enable (as v1);
  - stage 2 applies REQ-011 to the stage-1 contents when v1=1.
REQ-013 Latency: a word sampled at rising edge k SHALL drive valid_out=1 and the updated crc_out from edge k+1 until edge k+2.
REQ-014 valid_out SHALL equal the registered v1; it stays high on consecutive cycles only for back-to-back qualified words.
REQ-015 Throughput SHALL be one word per clock with no stalls.
  - Back-to-back words chain correctly: stage 2 seeds from the crc_out just produced by the previous word.
REQ-016 crc_out SHALL hold its value whenever stage 1 carries no qualified word (v1=0).
REQ-017 start_of_packet=1 on a mid-packet word SHALL restart the CRC from 0xFFFFFFFF for that word, discarding prior state.
REQ-018 start_of_packet=1 with enable=0 SHALL have no effect.
REQ-019 The first qualified word after reset without start_of_packet SHALL seed from the reset value 0xFFFFFFFF.

Reset
REQ-020 While reset_n=0 at a rising edge, the block SHALL apply these reset values:
  - valid_out=0, crc_out=0xFFFFFFFF;
  - all stage-1 registers cleared (v1=0).
REQ-021 Reset mid-packet SHALL discard in-flight words; no valid_out pulse SHALL appear for words sampled in the reset cycle or before it.
REQ-022 The first word sampled at the first edge with reset_n=1 SHALL be accepted normally.

Structure
REQ-023 Package crc32_pkg SHALL hold:
  - CRC_POLY=32'h04C11DB7 and CRC_INIT=32'hFFFFFFFF;
  - the pure function computing the 32-bit-data next-CRC.
REQ-024 Sub-module crc32_d32_next (combinational; inputs crc_in[31:0], data[31:0]; output crc_next[31:0]) SHALL implement the parallel update and be instantiated once in stage 2.
REQ-025 The top level SHALL contain only the two pipeline stages, the seed mux and the output registers.

Verification
REQ-026 Reset: hold reset_n=0 for 5 cycles -> valid_out=0, crc_out=0xFFFFFFFF.
REQ-027 Golden vector: one word 0x12345678 with sop=1, enable=1, then idle -> exactly one valid_out pulse, crc_out=0xDF8A8A2B, held afterwards.
REQ-028 Error detection: one word 0x12345679 with sop=1 -> crc_out=0xDB4B979C (differs from 0xDF8A8A2B).
REQ-029 Two-word packet, back to back:
  - stimulus: 0x12345678 (sop=1), then 0x9ABCDEF0 (sop=0);
  - response: valid_out high on two consecutive cycles; first crc_out=0xDF8A8A2B; second equals a bitwise MPEG-2 model over bytes 12 34 56 78 9A BC DE F0.
REQ-030 Restart and gating:
  - 0x12345678 with sop=1 twice back to back -> both results 0xDF8A8A2B;
  - sop=1 with enable=0 -> no valid_out pulse, crc_out unchanged.
REQ-031 Reset mid-packet: assert reset_n=0 one cycle after the first word -> no valid_out pulse for that word, crc_out=0xFFFFFFFF.
